// File: rtl/fpu_ss_pkg.sv
// Shared types for the FPU subsystem offload path: the offload table entry, the
// per-entry predecode metadata and the predecoder stage response.
package fpu_ss_pkg;

  localparam int unsigned InstrDataWidth = 32;
  // The stage response carries the index at a fixed width; the stage trims it to clog2(NumInstr).
  localparam int unsigned PrdIdxWidth    = 8;

  typedef struct packed {
    logic       accept;
    logic       writeback;
    logic       is_mem_op;
    logic [2:0] use_rs;
  } acc_prd_rsp_t;

  typedef struct packed {
    logic [InstrDataWidth-1:0] instr_data;
    logic [InstrDataWidth-1:0] instr_mask;
    acc_prd_rsp_t              prd_rsp;
  } offload_instr_t;

  typedef struct packed {
    logic                   accept;
    logic                   writeback;
    logic                   is_mem_op;
    logic [2:0]             use_rs;
    logic [PrdIdxWidth-1:0] match_idx;
    logic                   multi_hit;
  } prd_stage_rsp_t;

endpackage

// File: rtl/fpu_ss_predecoder_match.sv
// Combinational offload-table match: per-entry mask/data compare, lowest-index
// priority select of the metadata and detection of more than one hit.
module fpu_ss_predecoder_match
  import fpu_ss_pkg::*;
#(
  parameter int unsigned    NumInstr                 = 1,
  parameter offload_instr_t OffloadInstr [NumInstr]  = '{default: '0}
) (
  input  logic [InstrDataWidth-1:0] instr_i,
  output prd_stage_rsp_t            rsp_o
);

  logic [NumInstr-1:0] hit;

  generate
    for (genvar gi = 0; gi < NumInstr; gi++) begin : g_hit
      assign hit[gi] = (OffloadInstr[gi].instr_mask & instr_i) == OffloadInstr[gi].instr_data;
    end
  endgenerate

  // The first hit claims the response; any later hit only marks multi_hit.
  always_comb begin
    rsp_o = '0;
    for (int unsigned i = 0; i < NumInstr; i++) begin
      if (hit[i]) begin
        if (!rsp_o.accept) begin
          rsp_o.accept    = 1'b1;
          rsp_o.writeback = OffloadInstr[i].prd_rsp.writeback;
          rsp_o.is_mem_op = OffloadInstr[i].prd_rsp.is_mem_op;
          rsp_o.use_rs    = OffloadInstr[i].prd_rsp.use_rs;
          rsp_o.match_idx = PrdIdxWidth'(i);
        end else begin
          rsp_o.multi_hit = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fpu_ss_predecoder_stage.sv
// Registered predecoder stage: table match on the request side, one-entry
// valid/ready pipeline register on the response side, saturating perf counters.
module fpu_ss_predecoder_stage
  import fpu_ss_pkg::*;
#(
  parameter int unsigned    NumInstr                 = 1,
  parameter offload_instr_t OffloadInstr [NumInstr]  = '{default: '0},
  parameter int unsigned    InstrWidth               = 32,
  parameter int unsigned    IdWidth                  = 4,
  parameter int unsigned    CntWidth                 = 16,
  localparam int unsigned   IdxWidth                 = (NumInstr > 1) ? $clog2(NumInstr) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  q_valid_i,
  output logic                  q_ready_o,
  input  logic [InstrWidth-1:0] q_instr_data_i,
  input  logic [IdWidth-1:0]    q_id_i,
  output logic                  p_valid_o,
  input  logic                  p_ready_i,
  output logic [IdWidth-1:0]    p_id_o,
  output logic                  p_accept_o,
  output logic                  p_writeback_o,
  output logic                  p_is_mem_op_o,
  output logic [2:0]            p_use_rs_o,
  output logic [IdxWidth-1:0]   p_match_idx_o,
  output logic                  p_multi_hit_o,
  input  logic                  cnt_clr_i,
  output logic [CntWidth-1:0]   cnt_accept_o,
  output logic [CntWidth-1:0]   cnt_reject_o
);

  logic [InstrDataWidth-1:0] instr_ext;
  prd_stage_rsp_t            match_rsp;
  logic                      unused_match_idx;

  logic                      capture, out_hs;
  logic                      p_valid_q, p_valid_d;
  acc_prd_rsp_t              p_meta_q, p_meta_d;
  logic [IdxWidth-1:0]       p_idx_q, p_idx_d;
  logic                      p_multi_q, p_multi_d;
  logic [IdWidth-1:0]        p_id_q, p_id_d;
  logic [CntWidth-1:0]       cnt_accept_q, cnt_accept_d;
  logic [CntWidth-1:0]       cnt_reject_q, cnt_reject_d;

  assign instr_ext = InstrDataWidth'(q_instr_data_i);

  fpu_ss_predecoder_match #(
    .NumInstr     (NumInstr),
    .OffloadInstr (OffloadInstr)
  ) i_match (
    .instr_i (instr_ext),
    .rsp_o   (match_rsp)
  );

  assign unused_match_idx = ^match_rsp.match_idx;

  assign q_ready_o = !p_valid_q || p_ready_i;
  assign capture   = q_valid_i && q_ready_o;
  assign out_hs    = p_valid_q && p_ready_i;

  always_comb begin
    p_valid_d = p_valid_q;
    p_meta_d  = p_meta_q;
    p_idx_d   = p_idx_q;
    p_multi_d = p_multi_q;
    p_id_d    = p_id_q;
    if (capture) begin
      p_valid_d          = 1'b1;
      p_meta_d.accept    = match_rsp.accept;
      p_meta_d.writeback = match_rsp.writeback;
      p_meta_d.is_mem_op = match_rsp.is_mem_op;
      p_meta_d.use_rs    = match_rsp.use_rs;
      p_idx_d            = match_rsp.match_idx[IdxWidth-1:0];
      p_multi_d          = match_rsp.multi_hit;
      p_id_d             = q_id_i;
    end else if (out_hs) begin
      p_valid_d = 1'b0;
    end
  end

  // Counters see only delivered responses; clear beats a same-cycle increment.
  always_comb begin
    cnt_accept_d = cnt_accept_q;
    cnt_reject_d = cnt_reject_q;
    if (cnt_clr_i) begin
      cnt_accept_d = '0;
      cnt_reject_d = '0;
    end else if (out_hs) begin
      if (p_meta_q.accept) begin
        if (cnt_accept_q != '1) cnt_accept_d = cnt_accept_q + CntWidth'(1);
      end else begin
        if (cnt_reject_q != '1) cnt_reject_d = cnt_reject_q + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_valid_q    <= 1'b0;
      p_meta_q     <= '0;
      p_idx_q      <= '0;
      p_multi_q    <= 1'b0;
      p_id_q       <= '0;
      cnt_accept_q <= '0;
      cnt_reject_q <= '0;
    end else begin
      p_valid_q    <= p_valid_d;
      p_meta_q     <= p_meta_d;
      p_idx_q      <= p_idx_d;
      p_multi_q    <= p_multi_d;
      p_id_q       <= p_id_d;
      cnt_accept_q <= cnt_accept_d;
      cnt_reject_q <= cnt_reject_d;
    end
  end

  assign p_valid_o     = p_valid_q;
  assign p_id_o        = p_id_q;
  assign p_accept_o    = p_meta_q.accept;
  assign p_writeback_o = p_meta_q.writeback;
  assign p_is_mem_op_o = p_meta_q.is_mem_op;
  assign p_use_rs_o    = p_meta_q.use_rs;
  assign p_match_idx_o = p_idx_q;
  assign p_multi_hit_o = p_multi_q;
  assign cnt_accept_o  = cnt_accept_q;
  assign cnt_reject_o  = cnt_reject_q;

endmodule

// File: tb/tb_fpu_ss_predecoder_stage.sv
// Bench for the predecoder stage: directed cases with literal expectations plus
// a randomized phase checked every cycle against a transaction-level model.
module tb_fpu_ss_predecoder_stage;
  import fpu_ss_pkg::*;

  localparam int NI   = 3;
  localparam int CW   = 2;
  localparam int IDW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  localparam offload_instr_t TBL [NI] = '{
    '{instr_data: 32'h0000_0053, instr_mask: 32'hFE00_007F,
      prd_rsp: '{accept: 1'b1, writeback: 1'b1, is_mem_op: 1'b0, use_rs: 3'b011}},
    '{instr_data: 32'h0000_0053, instr_mask: 32'h0000_007F,
      prd_rsp: '{accept: 1'b1, writeback: 1'b0, is_mem_op: 1'b1, use_rs: 3'b001}},
    '{instr_data: 32'h0000_2007, instr_mask: 32'h0000_707F,
      prd_rsp: '{accept: 1'b1, writeback: 1'b1, is_mem_op: 1'b1, use_rs: 3'b001}}
  };

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           q_valid = 1'b0;
  logic           q_ready;
  logic [31:0]    q_instr = '0;
  logic [IDW-1:0] q_id = '0;
  logic           p_valid;
  logic           p_ready = 1'b1;
  logic [IDW-1:0] p_id;
  logic           p_accept, p_wb, p_mem, p_multi;
  logic [2:0]     p_use_rs;
  logic [1:0]     p_idx;
  logic           cnt_clr = 1'b0;
  logic [CW-1:0]  cnt_acc, cnt_rej;

  fpu_ss_predecoder_stage #(
    .NumInstr     (NI),
    .OffloadInstr (TBL),
    .InstrWidth   (32),
    .IdWidth      (IDW),
    .CntWidth     (CW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .q_valid_i      (q_valid),
    .q_ready_o      (q_ready),
    .q_instr_data_i (q_instr),
    .q_id_i         (q_id),
    .p_valid_o      (p_valid),
    .p_ready_i      (p_ready),
    .p_id_o         (p_id),
    .p_accept_o     (p_accept),
    .p_writeback_o  (p_wb),
    .p_is_mem_op_o  (p_mem),
    .p_use_rs_o     (p_use_rs),
    .p_match_idx_o  (p_idx),
    .p_multi_hit_o  (p_multi),
    .cnt_clr_i      (cnt_clr),
    .cnt_accept_o   (cnt_acc),
    .cnt_reject_o   (cnt_rej)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Transaction-level view: what a word decodes to, straight from the table rules.
  typedef struct {
    logic           accept;
    logic           wb;
    logic           mem;
    logic [2:0]     use_rs;
    int             idx;
    logic           multi;
    logic [IDW-1:0] id;
  } exp_t;

  function automatic exp_t predecode(input logic [31:0] w);
    exp_t e;
    int   hits = 0;
    e = '{accept: 1'b0, wb: 1'b0, mem: 1'b0, use_rs: 3'b000, idx: 0, multi: 1'b0, id: '0};
    for (int i = 0; i < NI; i++) begin
      if ((w & TBL[i].instr_mask) == TBL[i].instr_data) begin
        if (hits == 0) begin
          e.accept = 1'b1;
          e.wb     = TBL[i].prd_rsp.writeback;
          e.mem    = TBL[i].prd_rsp.is_mem_op;
          e.use_rs = TBL[i].prd_rsp.use_rs;
          e.idx    = i;
        end
        hits++;
      end
    end
    e.multi = (hits >= 2);
    return e;
  endfunction

  exp_t m_out;
  bit   m_valid = 1'b0;
  int   m_cacc  = 0;
  int   m_crej  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_cacc  <= 0;
      m_crej  <= 0;
    end else begin
      bit   hs, cap;
      exp_t nxt;
      hs  = m_valid && p_ready;
      cap = q_valid && (!m_valid || p_ready);
      if (cnt_clr) begin
        m_cacc <= 0;
        m_crej <= 0;
      end else if (hs) begin
        if (m_out.accept) m_cacc <= (m_cacc < CMAX) ? m_cacc + 1 : CMAX;
        else              m_crej <= (m_crej < CMAX) ? m_crej + 1 : CMAX;
      end
      if (hs)
        $display("txn id=%0d accept=%0b wb=%0b mem=%0b use_rs=%03b idx=%0d multi=%0b",
                 m_out.id, m_out.accept, m_out.wb, m_out.mem, m_out.use_rs, m_out.idx, m_out.multi);
      if (cap) begin
        nxt     = predecode(q_instr);
        nxt.id  = q_id;
        m_out   <= nxt;
        m_valid <= 1'b1;
      end else if (hs) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("m_q_ready", q_ready, (!m_valid || p_ready));
      chk("m_p_valid", p_valid, m_valid);
      chk("m_cnt_accept", cnt_acc, m_cacc);
      chk("m_cnt_reject", cnt_rej, m_crej);
      if (m_valid) begin
        chk("m_p_id", p_id, m_out.id);
        chk("m_p_accept", p_accept, m_out.accept);
        chk("m_p_writeback", p_wb, m_out.wb);
        chk("m_p_is_mem_op", p_mem, m_out.mem);
        chk("m_p_use_rs", p_use_rs, m_out.use_rs);
        chk("m_p_match_idx", p_idx, m_out.idx);
        chk("m_p_multi_hit", p_multi, m_out.multi);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic [IDW-1:0] id);
    q_valid = 1'b1;
    q_instr = w;
    q_id    = id;
    step();
    q_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_p_valid", p_valid, 0);
    chk("rst_p_id", p_id, 0);
    chk("rst_p_accept", p_accept, 0);
    chk("rst_cnt_accept", cnt_acc, 0);
    chk("rst_cnt_reject", cnt_rej, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_q_ready", q_ready, 1);
    cmp_en = 1'b1;
    step();

    // Basic accept, entries 0 and 1 both hit: entry 0 wins
    send(32'h0020_8053, 4'd5);
    chk("basic_p_valid", p_valid, 1);
    chk("basic_accept", p_accept, 1);
    chk("basic_wb", p_wb, 1);
    chk("basic_use_rs", p_use_rs, 3'b011);
    chk("basic_idx", p_idx, 0);
    chk("basic_id", p_id, 5);
    chk("basic_multi_hit", p_multi, 1);
    step();
    chk("basic_cnt_accept", cnt_acc, 1);
    chk("basic_p_valid_drop", p_valid, 0);

    // Reject (addi)
    send(32'h0000_0013, 4'd2);
    chk("rej_accept", p_accept, 0);
    chk("rej_wb", p_wb, 0);
    chk("rej_mem", p_mem, 0);
    chk("rej_use_rs", p_use_rs, 0);
    chk("rej_idx", p_idx, 0);
    chk("rej_multi", p_multi, 0);
    step();
    chk("rej_cnt_reject", cnt_rej, 1);
    chk("rej_cnt_accept", cnt_acc, 1);

    // funct7!=0 only hits entry 1
    send(32'h0220_8053, 4'd3);
    chk("e1_idx", p_idx, 1);
    chk("e1_wb", p_wb, 0);
    chk("e1_mem", p_mem, 1);
    chk("e1_multi", p_multi, 0);
    step();

    // FLW only hits entry 2
    send(32'h0000_A087, 4'd4);
    chk("e2_idx", p_idx, 2);
    chk("e2_mem", p_mem, 1);
    chk("e2_use_rs", p_use_rs, 3'b001);
    step();
    chk("e2_cnt_accept", cnt_acc, 3);

    // Backpressure: response held, new offers ignored
    p_ready = 1'b0;
    send(32'h0020_8053, 4'd7);
    for (int i = 0; i < 4; i++) begin
      q_valid = 1'b1;
      q_instr = 32'h0000_0053 | ($urandom & 32'h01FF_FF80);
      q_id    = IDW'(8 + i);
      step();
      chk("bp_q_ready", q_ready, 0);
      chk("bp_p_id", p_id, 7);
      chk("bp_p_valid", p_valid, 1);
      chk("bp_cnt_accept", cnt_acc, 3);
    end
    p_ready = 1'b1;
    q_instr = 32'h0000_0013;
    q_id    = 4'd12;
    step();
    chk("bb_id12", p_id, 12);
    q_instr = 32'h0220_8053;
    q_id    = 4'd13;
    step();
    chk("bb_id13", p_id, 13);
    chk("bb_valid", p_valid, 1);
    q_valid = 1'b0;
    step();
    chk("bb_drain", p_valid, 0);
    chk("bb_cnt_accept_sat", cnt_acc, 3);
    chk("bb_cnt_reject", cnt_rej, 2);

    // Saturation then clear
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_accept", cnt_acc, 0);
    chk("clr_reject", cnt_rej, 0);
    q_valid = 1'b1;
    q_instr = 32'h0020_8053;
    for (int i = 0; i < 5; i++) begin
      q_id = IDW'(i);
      step();
    end
    q_valid = 1'b0;
    step();
    chk("sat_cnt_accept", cnt_acc, 3);
    send(32'h0020_8053, 4'd9);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_hs_cnt_accept", cnt_acc, 0);
    chk("clr_hs_p_valid", p_valid, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      int e;
      q_valid = ($urandom_range(3) != 0);
      p_ready = ($urandom_range(2) != 0);
      cnt_clr = ($urandom_range(49) == 0);
      q_id    = IDW'($urandom);
      e       = $urandom_range(3);
      if (e == 3) q_instr = $urandom;
      else        q_instr = ($urandom & ~TBL[e].instr_mask) | TBL[e].instr_data;
      step();
    end
    q_valid = 1'b0;
    cnt_clr = 1'b0;
    p_ready = 1'b1;
    step();
    step();

    // Async reset with a pending response and non-zero counters
    send(32'h0020_8053, 4'd1);
    p_ready = 1'b0;
    send(32'h0000_0013, 4'd6);
    chk("ar_pending", p_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_p_valid", p_valid, 0);
    chk("ar_cnt_accept", cnt_acc, 0);
    chk("ar_cnt_reject", cnt_rej, 0);
    chk("ar_q_ready", q_ready, 1);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    p_ready = 1'b1;
    step();
    chk("ar_after_p_valid", p_valid, 0);
    chk("ar_after_cnt_reject", cnt_rej, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_ss_predecoder_stage.md
Name: fpu_ss_predecoder_stage

Overview:
Registered, flow-controlled predecoder for the FPU subsystem offload path.
- Matches each offered instruction word against a parametrised table of mask/data entries.
- The lowest matching table index wins; the block flags when more than one entry matches.
- Returns accept/writeback/mem-op/use-rs metadata through a one-entry pipeline register with valid/ready on both sides.
- Keeps saturating accept/reject counters for performance monitoring.
- Sits between the core's X-interface offload request and the FPU subsystem dispatch.

Parameters:
- NumInstr, 1, number of entries in the offload table (>=1).
- OffloadInstr, all-zero table, array[NumInstr] of fpu_ss_pkg::offload_instr_t (instr_data, instr_mask, prd_rsp).
- InstrWidth, 32, instruction word width.
- IdWidth, 4, transaction id width, passed through unchanged.
- CntWidth, 16, width of each performance counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- q_valid_i  in  1  request valid
- q_ready_o  out  1  request ready
- q_instr_data_i  in  InstrWidth  instruction word
- q_id_i  in  IdWidth  transaction id
- p_valid_o  out  1  response valid
- p_ready_i  in  1  response ready
- p_id_o  out  IdWidth  id of the registered request
- p_accept_o  out  1  some entry matched
- p_writeback_o  out  1  metadata of the winning entry
- p_is_mem_op_o  out  1  metadata of the winning entry
- p_use_rs_o  out  3  metadata of the winning entry
- p_match_idx_o  out  max(1,$clog2(NumInstr))  index of the winning entry
- p_multi_hit_o  out  1  two or more entries matched
- cnt_clr_i  in  1  synchronous clear of both counters
- cnt_accept_o  out  CntWidth  accepted responses delivered
- cnt_reject_o  out  CntWidth  rejected responses delivered

Behaviour:
- Reset: all registers asynchronously cleared on rst_ni=0.
  - p_valid_o=0; every p_* field=0; both counters=0.
  - q_ready_o=1 as soon as rst_ni is released.
- Match rule: entry i hits when (instr_mask[i] & q_instr_data_i) == instr_data[i]. Evaluated combinationally on the input side.
- Priority: the lowest hit index selects the metadata and p_match_idx.
- No hit: accept=0, writeback=0, is_mem_op=0, use_rs=0, match_idx=0.
- p_multi_hit is set when the popcount of hits is >=2. p_accept is still 1 in that case.
- Pipeline register: single entry, latency 1 cycle. A request captured at edge N is visible with p_valid_o=1 after edge N.
- q_ready_o = !p_valid_o || p_ready_i. This is a combinational path from p_ready_i, with full throughput of 1 per cycle.
- Capture happens when q_valid_i && q_ready_o. All p_* fields and p_id_o load together.
- Output handshake is p_valid_o && p_ready_i.
  - If there is a capture in the same cycle, p_valid stays 1 and the new data is loaded.
  - Otherwise p_valid_o goes to 0. Payload registers keep their stale value, which is don't-care while invalid.
- Stability: while p_valid_o && !p_ready_i, all p_* outputs hold constant. The q_* inputs are ignored.
- Counters:
  - On an output handshake, cnt_accept increments if p_accept_o=1; otherwise cnt_reject increments.
  - Each counter saturates at 2^CntWidth-1 and does not wrap.
  - cnt_clr_i has priority over an increment in the same cycle; the result is 0.
- Reset mid-transaction: a pending response is dropped with no handshake and is not counted.
- NumInstr=1: p_match_idx_o is 1 bit and always 0.

Decomposition:
- fpu_ss_pkg: offload_instr_t and acc_prd_rsp_t are reused unchanged. Add typedef prd_stage_rsp_t holding accept, writeback, is_mem_op, use_rs, match_idx, multi_hit.
- Sub-module fpu_ss_predecoder_match: purely combinational table match plus lowest-index priority encoder plus multi-hit detection. Parameters: NumInstr, OffloadInstr.
- The top level holds the pipeline register, the handshake and the counters.

Test Plan:
- Basic accept: table entry0 {mask 0xFE00007F, data 0x00000053, wb=1, use_rs=3'b011}; send 0x00208053 with id 5 and p_ready=1. The next cycle shows p_valid=1, accept=1, wb=1, use_rs=3'b011, idx=0, id=5; cnt_accept=1 after the handshake.
- Reject: send 0x00000013 (addi). The response has accept=0 and all metadata 0; cnt_reject increments to 1 and cnt_accept is unchanged.
- Priority and multi-hit: entry0 and entry1 both match 0x00208053, with entry1 wb=0 and entry0 wb=1. The response has idx=0, wb=1, multi_hit=1.
- Backpressure: hold p_ready=0 for 4 cycles while q_valid=1 offers new words. q_ready=0, the outputs are unchanged, and no counter moves. Releasing p_ready gives back-to-back responses at 1 per cycle with no loss or duplication.
- Saturation and clear: with CntWidth=2, deliver 5 accepts; cnt_accept stays at 3. Assert cnt_clr_i in the same cycle as a handshake; the counter reads 0.
- Async reset: assert rst_ni=0 mid-cycle while p_valid=1. p_valid_o drops immediately with no clock edge needed, and the counters read 0.
